// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: config handshake carrying the count limit and reload mode
interface counter_sequencer_if #(parameter int WIDTH = 4);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] limit;
  logic             mode;
  modport master(output valid, limit, mode, input ready);
  modport slave(input valid, limit, mode, output ready);
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer: run controller owning a modulo counter with configurable limit,
// one-shot/auto-reload mode, pause/abort control and a registered wrap pulse.
module counter_sequencer #(
  parameter int WIDTH         = 4,
  parameter int DEFAULT_LIMIT = 9
) (
  input  logic                clk,
  input  logic                reset,
  counter_sequencer_if.slave  cfg,
  input  logic                start,
  input  logic                pause,
  input  logic                abort,
  output logic [WIDTH-1:0]    q,
  output logic                tc,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] limit, q_nx;
  logic             mode, tc_nx;
  assign cfg.ready = state == IDLE || state == DONE;
  assign busy      = state == RUN || state == HOLD;
  assign done      = state == DONE;
  always_comb begin
    state_nx = state;
    q_nx     = q;
    tc_nx    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx = RUN;
        q_nx     = '0;
      end
      DONE: state_nx = start ? RUN : abort ? IDLE : DONE;
      RUN: if (abort) begin
        state_nx = IDLE;
        q_nx     = '0;
      end else if (pause) begin
        state_nx = HOLD;
      end else if (q == limit) begin
        q_nx     = '0;
        tc_nx    = 1'b1;
        state_nx = mode ? RUN : DONE;
      end else begin
        q_nx = q + 1'b1;
      end
      HOLD: if (abort) begin
        state_nx = IDLE;
        q_nx     = '0;
      end else if (!pause) begin
        state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q     <= '0;
      tc    <= 1'b0;
      limit <= WIDTH'(DEFAULT_LIMIT);
      mode  <= 1'b0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      tc    <= tc_nx;
      if (cfg.valid && cfg.ready) begin
        limit <= cfg.limit;
        mode  <= cfg.mode;
      end
    end
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed scenarios plus random stimulus, each cycle compared
// against a behavioural model of the run controller.
module tb_counter_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [3:0] q;
  logic       tc, busy, done;
  int         n_chk = 0, n_pass = 0;
  bit         active = 0, held = 0, fin = 0, auto_m = 0, tc_m = 0;
  int         cnt = 0, lim = 9;
  counter_sequencer_if #(.WIDTH(4)) cif ();
  counter_sequencer #(.WIDTH(4), .DEFAULT_LIMIT(9)) dut (
    .clk(clk), .reset(reset), .cfg(cif.slave), .start(start), .pause(pause),
    .abort(abort), .q(q), .tc(tc), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".q"}, int'(q), cnt);
    chk({tag, ".tc"}, int'(tc), int'(tc_m));
    chk({tag, ".busy"}, int'(busy), int'(active));
    chk({tag, ".done"}, int'(done), int'(fin));
    chk({tag, ".ready"}, int'(cif.ready), int'(!active));
  endtask
  task automatic model_reset();
    active = 0; held = 0; fin = 0; auto_m = 0; tc_m = 0; cnt = 0; lim = 9;
  endtask
  task automatic model_edge();
    if (!active && cif.valid) begin
      lim    = int'(cif.limit);
      auto_m = cif.mode;
    end
    tc_m = 0;
    if (!active) begin
      if (start) begin
        active = 1; held = 0; fin = 0; cnt = 0;
      end else if (abort) fin = 0;
    end else if (abort) begin
      active = 0; held = 0; cnt = 0;
    end else if (held) begin
      held = pause;
    end else if (pause) begin
      held = 1;
    end else if (cnt == lim) begin
      cnt = 0; tc_m = 1;
      if (!auto_m) begin
        active = 0; fin = 1;
      end
    end else cnt = (cnt + 1) % 16;
  endtask
  task automatic step(input string tag, input bit st, input bit pa, input bit ab,
                      input bit cv = 0, input int cl = 0, input bit cm = 0);
    start = st; pause = pa; abort = ab;
    cif.valid = cv; cif.limit = 4'(cl); cif.mode = cm;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0);
  endtask
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 reset = 1'b1;
  endtask
  initial begin
    cif.valid = 0; cif.limit = '0; cif.mode = 0;
    #3;
    check_all("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    // decade one-shot with the reset-time limit
    step("t1start", 1, 0, 0);
    idle("t1run", 12);
    // limit 3 auto-reload; config offered mid-run must be ignored
    step("t2cfg", 0, 0, 0, 1, 3, 1);
    step("t2start", 1, 0, 0);
    idle("t2run", 6);
    step("t2cfgrun", 0, 0, 0, 1, 9, 0);
    idle("t2keep", 6);
    step("t2abort", 0, 0, 1);
    // limit 7 auto, pause at q=2 for 3 cycles
    step("t3cfg", 0, 0, 0, 1, 7, 1);
    step("t3start", 1, 0, 0);
    idle("t3run", 2);
    for (int i = 0; i < 3; i++) step("t3pause", 0, 1, 0);
    idle("t3resume", 10);
    step("t3abort", 0, 0, 1);
    // abort in HOLD at q=5, then pause+abort together
    step("t4start", 1, 0, 0);
    idle("t4run", 5);
    step("t4pause", 0, 1, 0);
    step("t4hold", 0, 1, 0);
    step("t4abort", 0, 1, 1);
    step("t4start2", 1, 0, 0);
    idle("t4run2", 3);
    step("t4both", 0, 1, 1);
    idle("t4idle", 2);
    // asynchronous reset mid-run at q=6, then default decade again
    step("t5cfg", 0, 0, 0, 1, 12, 1);
    step("t5start", 1, 0, 0);
    idle("t5run", 6);
    async_reset("t5rst");
    step("t5start2", 1, 0, 0);
    idle("t5run2", 11);
    // full-range one-shot, then limit 0 loaded on the start edge
    step("t6cfg", 0, 0, 0, 1, 15, 0);
    step("t6start", 1, 0, 0);
    idle("t6run", 17);
    step("t6zero", 1, 0, 0, 1, 0, 0);
    idle("t6zrun", 3);
    step("t6zauto", 1, 0, 0, 1, 0, 1);
    idle("t6zarun", 4);
    step("t6abort", 0, 0, 1);
    step("t6done", 1, 0, 0, 1, 0, 0);
    idle("t6dwait", 2);
    step("t6dabort", 0, 0, 1);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) async_reset("rndrst");
      step("rnd", $urandom_range(9) == 0, $urandom_range(6) == 0, $urandom_range(19) == 0,
           $urandom_range(4) == 0, int'($urandom_range(15)), 1'($urandom_range(1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
